i2c_codec_responder: RTL and testbench
======================================

Name: i2c_codec_responder

Overview:
Synthesizable I2C write-only responder: the device end of the WM8731 control bus that I2cInitializer drives. It decodes START/STOP, matches the 7-bit device address and acknowledges. It stores the 3-byte WM8731 register writes (address byte, {reg[6:0], data[8]}, data[7:0]) into a shadow register file. It serves as an on-chip codec stand-in for simulation/FPGA loopback and as a bus monitor that confirms the initializer's settings.

Parameters:
DEV_ADDR, 7'h1A, 7-bit device address to acknowledge.
NUM_REGS, 10, number of shadow registers R0..R(NUM_REGS-1), each 9 bits.
RESET_REG, 7'h0F, register index whose write clears the whole register file.

Ports:
i_clk  input  1  system clock; must be at least 8x the SCL frequency.
i_rst_n  input  1  synchronous active-low reset.
i_scl  input  1  I2C SCL as seen on the bus (asynchronous).
i_sda  input  1  I2C SDA as seen on the bus (asynchronous).
o_sda_oen  output  1  1 = pull SDA low (ACK); 0 = release (high-Z).
i_rd_idx  input  4  shadow register index for read-back.
o_rd_data  output  9  combinational read of register[i_rd_idx]; 0 if index >= NUM_REGS.
o_wr_valid  output  1  one-cycle pulse when a write commits.
o_wr_addr  output  7  register index of the last committed write; held until the next commit.
o_wr_data  output  9  data of the last committed write; held until the next commit.
o_err  output  1  one-cycle pulse on protocol or range error.
o_wr_count  output  8  committed-write counter; wraps 255->0.
o_busy  output  1  1 from START until STOP or abort.

Behaviour:
- Reset: single clock i_clk; reset is synchronous, active-low (i_rst_n sampled on posedge i_clk). All outputs are 0, all registers are 0, and the state is IDLE. Reset mid-transfer releases SDA on the next edge.
- Input conditioning: i_scl and i_sda each pass through a 2-flop synchronizer plus a 1-flop edge register. Bus events are acted on 3 i_clk cycles after the pin change.
- START: SDA falls while SCL is high. Accepted from any state, including repeated START, which restarts at ADDR and discards a partial write.
- STOP: SDA rises while SCL is high. From any state it goes to IDLE. If a write has not committed, it is discarded and o_err pulses, except when the STOP arrives in IDLE or WAIT_STOP.
- Data sampling: SDA is sampled on each SCL rising edge and shifted in MSB first. A 3-bit bit counter is cleared on entering each byte.
- States:
  - IDLE: waits for START.
  - ADDR: takes 8 bits.
  - ACK_A: address-byte acknowledge.
  - BYTE1: takes 8 bits.
  - ACK_1: byte-1 acknowledge.
  - BYTE2: takes 8 bits.
  - ACK_2: byte-2 acknowledge.
  - WAIT_STOP: ignores bits, never drives SDA, waits for START or STOP.
- ACK timing: on the SCL falling edge after the 8th bit, assert o_sda_oen. Hold it through the ACK clock and release it on the next SCL falling edge, which also enters the next state.
- ADDR decode:
  - {addr, rw} with addr == DEV_ADDR and rw == 0: ACK, go to BYTE1.
  - addr mismatch: no ACK, go to WAIT_STOP, no o_err (another device's traffic).
  - addr match with rw == 1: no ACK, o_err pulse, WAIT_STOP.
- BYTE1 and BYTE2 are always ACKed. After the ACK_2 release, the state is WAIT_STOP; a 4th byte is NACKed by never driving SDA.
- Commit happens in the cycle ACK_2 begins, i.e. the same cycle o_sda_oen rises:
  - reg = byte1[7:1], data = {byte1[0], byte2}.
  - If reg < NUM_REGS: write register[reg] = data.
  - If reg == RESET_REG: clear all registers (data ignored).
  - Otherwise: register file unchanged and o_err pulses.
  - In all three cases o_wr_valid pulses, o_wr_addr/o_wr_data update and o_wr_count increments.
- o_busy: 1 from the START detection cycle until the STOP detection cycle, or until reset.
- SCL edge while SDA changes simultaneously: the SCL edge takes precedence in the same cycle. A START/STOP is recognised only while the synchronized SCL is high and stable.

Test Plan:
- START, 0x34, 0x12, 0x01, STOP -> 3 ACKs (SDA low in each 9th clock), o_wr_valid single pulse, o_wr_addr=0x09, o_wr_data=0x001, register[9]=0x001, o_wr_count=1, o_err never.
- Preload R2=0x079, then START, 0x34, 0x1E, 0x00, STOP -> ACKs, all registers 0, o_wr_addr=0x0F, no o_err.
- START, 0x36, ... -> no ACK on the address byte, no commit, o_err=0, o_busy=1 until STOP.
- START, 0x35 -> NACK, o_err pulse; following bytes ignored until STOP.
- START, 0x34, 0x04, then STOP before byte 2 -> no commit, R2 unchanged, o_err pulse, o_busy falls.
- START, 0x34, 0x16, then repeated START, 0x34, 0x0C, 0x00, STOP -> only R6=0x000 committed, o_wr_count+1; a reset asserted mid-byte drops o_sda_oen to 0 on the next edge.

Source files
------------

// File: rtl/i2c_codec_responder_if.sv
// I2C bus bundle between a bus master (or bench) and the codec responder.
// sda_oen is the responder's open-drain request: 1 pulls SDA low.
`timescale 1ns/1ps
interface i2c_codec_responder_if;
   logic scl;
   logic sda;
   logic sda_oen;

   modport master (output scl, output sda, input sda_oen);
   modport slave  (input scl, input sda, output sda_oen);
endinterface

// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder standing in for a WM8731 control port.
// Decodes START/STOP, acknowledges its device address, collects the
// 3-byte register write and keeps a 9-bit shadow register file.
`timescale 1ns/1ps
module i2c_codec_responder #(
   parameter logic [6:0] DEV_ADDR  = 7'h1A,
   parameter int         NUM_REGS  = 10,
   parameter logic [6:0] RESET_REG = 7'h0F
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   i2c_codec_responder_if.slave bus,
   input  logic [3:0]           i_rd_idx,
   output logic [8:0]           o_rd_data,
   output logic                 o_wr_valid,
   output logic [6:0]           o_wr_addr,
   output logic [8:0]           o_wr_data,
   output logic                 o_err,
   output logic [7:0]           o_wr_count,
   output logic                 o_busy
);

   localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [7:0] NUM_REGS_U = 8'(NUM_REGS);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ADDR      = 3'd1;
   localparam logic [2:0] ST_ACK_A     = 3'd2;
   localparam logic [2:0] ST_BYTE1     = 3'd3;
   localparam logic [2:0] ST_ACK_1     = 3'd4;
   localparam logic [2:0] ST_BYTE2     = 3'd5;
   localparam logic [2:0] ST_ACK_2     = 3'd6;
   localparam logic [2:0] ST_WAIT_STOP = 3'd7;

   logic       scl_p0, scl_p1, scl_p2;
   logic       sda_p0, sda_p1, sda_p2;

   logic [2:0] state;
   logic [2:0] bit_cnt;
   logic       got8;
   logic [7:0] shift;
   logic [7:0] byte1;
   logic       sda_oen_q;

   logic [8:0] regs [NUM_REGS];

   logic       scl_rise, scl_fall, scl_hi_stable;
   logic       start_det, stop_det;
   logic       in_byte, abort_err;
   logic       commit_now, reg_in_range, is_reset_reg;
   logic [6:0] commit_reg;
   logic [8:0] commit_data;

   assign bus.sda_oen = sda_oen_q;

   // Bus synchronizers: stage 0/1 resynchronize, stage 2 holds the previous value for edge detect
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         scl_p0 <= 1'b0;
         scl_p1 <= 1'b0;
         scl_p2 <= 1'b0;
         sda_p0 <= 1'b0;
         sda_p1 <= 1'b0;
         sda_p2 <= 1'b0;
      end else begin
         scl_p0 <= bus.scl;
         scl_p1 <= scl_p0;
         scl_p2 <= scl_p1;
         sda_p0 <= bus.sda;
         sda_p1 <= sda_p0;
         sda_p2 <= sda_p1;
      end
   end

   // Bus event decode and commit qualification
   always_comb begin
      scl_rise      = scl_p1 & ~scl_p2;
      scl_fall      = ~scl_p1 & scl_p2;
      // START/STOP only while SCL has been high for two samples, so an SCL edge always wins
      scl_hi_stable = scl_p1 & scl_p2;
      start_det     = scl_hi_stable & ~sda_p1 & sda_p2;
      stop_det      = scl_hi_stable & sda_p1 & ~sda_p2;
      in_byte       = (state == ST_ADDR) || (state == ST_BYTE1) || (state == ST_BYTE2);
      // A STOP here abandons a write that has not yet committed
      abort_err     = (state == ST_ADDR)  || (state == ST_ACK_A) ||
                      (state == ST_BYTE1) || (state == ST_ACK_1) ||
                      (state == ST_BYTE2);
      commit_now    = (state == ST_BYTE2) && scl_fall && got8;
      commit_reg    = byte1[7:1];
      commit_data   = {byte1[0], shift};
      reg_in_range  = {1'b0, commit_reg} < NUM_REGS_U;
      is_reset_reg  = (commit_reg == RESET_REG);
   end

   // Protocol FSM: byte reception, ACK drive, commit reporting and status
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= 3'd0;
         got8       <= 1'b0;
         shift      <= 8'd0;
         byte1      <= 8'd0;
         sda_oen_q  <= 1'b0;
         o_wr_valid <= 1'b0;
         o_wr_addr  <= 7'd0;
         o_wr_data  <= 9'd0;
         o_err      <= 1'b0;
         o_wr_count <= 8'd0;
         o_busy     <= 1'b0;
      end else begin
         o_wr_valid <= 1'b0;
         o_err      <= 1'b0;
         if (start_det) begin
            // START or repeated START: restart address phase, drop any partial write
            state     <= ST_ADDR;
            bit_cnt   <= 3'd0;
            got8      <= 1'b0;
            sda_oen_q <= 1'b0;
            o_busy    <= 1'b1;
         end else if (stop_det) begin
            if (abort_err) begin
               o_err <= 1'b1;
            end
            state     <= ST_IDLE;
            got8      <= 1'b0;
            sda_oen_q <= 1'b0;
            o_busy    <= 1'b0;
         end else if (in_byte && scl_rise && !got8) begin
            shift   <= {shift[6:0], sda_p1};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               got8 <= 1'b1;
            end
         end else if (scl_fall) begin
            case (state)
               ST_ADDR: begin
                  if (got8) begin
                     got8 <= 1'b0;
                     if (shift[7:1] != DEV_ADDR) begin
                        state <= ST_WAIT_STOP;
                     end else if (shift[0]) begin
                        // Reads are not supported: refuse and flag
                        o_err <= 1'b1;
                        state <= ST_WAIT_STOP;
                     end else begin
                        state     <= ST_ACK_A;
                        sda_oen_q <= 1'b1;
                     end
                  end
               end
               ST_BYTE1: begin
                  if (got8) begin
                     got8      <= 1'b0;
                     byte1     <= shift;
                     state     <= ST_ACK_1;
                     sda_oen_q <= 1'b1;
                  end
               end
               ST_BYTE2: begin
                  if (got8) begin
                     got8       <= 1'b0;
                     state      <= ST_ACK_2;
                     sda_oen_q  <= 1'b1;
                     o_wr_valid <= 1'b1;
                     o_wr_addr  <= commit_reg;
                     o_wr_data  <= commit_data;
                     o_wr_count <= o_wr_count + 8'd1;
                     if (!is_reset_reg && !reg_in_range) begin
                        o_err <= 1'b1;
                     end
                  end
               end
               ST_ACK_A: begin
                  sda_oen_q <= 1'b0;
                  bit_cnt   <= 3'd0;
                  state     <= ST_BYTE1;
               end
               ST_ACK_1: begin
                  sda_oen_q <= 1'b0;
                  bit_cnt   <= 3'd0;
                  state     <= ST_BYTE2;
               end
               ST_ACK_2: begin
                  sda_oen_q <= 1'b0;
                  state     <= ST_WAIT_STOP;
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

   // Shadow register file: indexed write, or whole-file clear on the reset register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= 9'd0;
         end
      end else if (commit_now) begin
         if (is_reset_reg) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               regs[i] <= 9'd0;
            end
         end else if (reg_in_range) begin
            regs[commit_reg[IDX_W-1:0]] <= commit_data;
         end
      end
   end

   // Combinational read-back, zero outside the implemented range
   always_comb begin
      o_rd_data = 9'd0;
      if ({4'd0, i_rd_idx} < NUM_REGS_U) begin
         o_rd_data = regs[i_rd_idx[IDX_W-1:0]];
      end
   end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: drives I2C write traffic as a
// bus master and checks ACKs, commits, errors and the shadow registers.
`timescale 1ns/1ps
module tb_i2c_codec_responder;
   localparam int Q = 10;   // clocks per quarter SCL period

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic [3:0] rd_idx = 4'd0;
   logic [8:0] o_rd_data;
   logic       o_wr_valid;
   logic [6:0] o_wr_addr;
   logic [8:0] o_wr_data;
   logic       o_err;
   logic [7:0] o_wr_count;
   logic       o_busy;

   int n_chk = 0;
   int n_fail = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int v0, e0;
   logic a0, a1, a2;

   always #5 clk = ~clk;

   i2c_codec_responder_if bus ();
   assign bus.scl = scl_drv;
   assign bus.sda = sda_drv & ~bus.sda_oen;

   i2c_codec_responder dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .bus        (bus),
      .i_rd_idx   (rd_idx),
      .o_rd_data  (o_rd_data),
      .o_wr_valid (o_wr_valid),
      .o_wr_addr  (o_wr_addr),
      .o_wr_data  (o_wr_data),
      .o_err      (o_err),
      .o_wr_count (o_wr_count),
      .o_busy     (o_busy)
   );

   // Count single-cycle pulses
   always @(posedge clk) begin
      if (o_wr_valid) valid_cnt <= valid_cnt + 1;
      if (o_err)      err_cnt   <= err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; wq();
      scl_drv = 1'b1; wq();
      sda_drv = 1'b0; wq();
      scl_drv = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; wq();
      scl_drv = 1'b1; wq();
      sda_drv = 1'b1; wq();
   endtask

   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_drv = b[i]; wq();
         scl_drv = 1'b1; wq(); wq();
         scl_drv = 1'b0; wq();
      end
   endtask

   task automatic ack_clock(output logic a);
      sda_drv = 1'b1; wq();
      scl_drv = 1'b1; wq();
      a = ~bus.sda;   wq();
      scl_drv = 1'b0; wq();
   endtask

   task automatic i2c_byte(input logic [7:0] b, output logic a);
      send_bits(b);
      ack_clock(a);
   endtask

   task automatic xfer3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        output logic k0, output logic k1, output logic k2);
      i2c_start();
      i2c_byte(b0, k0);
      i2c_byte(b1, k1);
      i2c_byte(b2, k2);
      i2c_stop();
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] idx, input logic [8:0] exp);
      rd_idx = idx;
      #1;
      chk(tag, 32'(o_rd_data), 32'(exp));
   endtask

   initial begin
      // Reset state
      repeat (5) @(posedge clk);
      #1;
      chk("rst_oen",   32'(bus.sda_oen), 32'd0);
      chk("rst_busy",  32'(o_busy), 32'd0);
      chk("rst_count", 32'(o_wr_count), 32'd0);
      chk("rst_waddr", 32'(o_wr_addr), 32'd0);
      rd_chk("rst_r9", 4'd9, 9'h000);
      rst_n = 1'b1;
      wq();

      // Basic write R9 = 0x001
      v0 = valid_cnt; e0 = err_cnt;
      i2c_start();
      chk("t1_busy_on", 32'(o_busy), 32'd1);
      i2c_byte(8'h34, a0);
      i2c_byte(8'h12, a1);
      i2c_byte(8'h01, a2);
      i2c_stop();
      chk("t1_acks", 32'({a0, a1, a2}), 32'h7);
      chk("t1_valid", 32'(valid_cnt - v0), 32'd1);
      chk("t1_err", 32'(err_cnt - e0), 32'd0);
      chk("t1_waddr", 32'(o_wr_addr), 32'h09);
      chk("t1_wdata", 32'(o_wr_data), 32'h001);
      chk("t1_count", 32'(o_wr_count), 32'd1);
      chk("t1_busy_off", 32'(o_busy), 32'd0);
      rd_chk("t1_r9", 4'd9, 9'h001);

      // Preload R2, then reset-register write clears the file
      e0 = err_cnt;
      xfer3(8'h34, 8'h04, 8'h79, a0, a1, a2);
      rd_chk("t2_r2_pre", 4'd2, 9'h079);
      xfer3(8'h34, 8'h1E, 8'h00, a0, a1, a2);
      chk("t2_acks", 32'({a0, a1, a2}), 32'h7);
      rd_chk("t2_r2", 4'd2, 9'h000);
      rd_chk("t2_r9", 4'd9, 9'h000);
      chk("t2_waddr", 32'(o_wr_addr), 32'h0F);
      chk("t2_err", 32'(err_cnt - e0), 32'd0);
      chk("t2_count", 32'(o_wr_count), 32'd3);

      // Foreign address: ignored silently
      v0 = valid_cnt; e0 = err_cnt;
      i2c_start();
      i2c_byte(8'h36, a0);
      i2c_byte(8'h12, a1);
      chk("t3_busy", 32'(o_busy), 32'd1);
      i2c_stop();
      chk("t3_acks", 32'({a0, a1}), 32'h0);
      chk("t3_valid", 32'(valid_cnt - v0), 32'd0);
      chk("t3_err", 32'(err_cnt - e0), 32'd0);
      chk("t3_busy_off", 32'(o_busy), 32'd0);

      // Read request: NACK plus error, rest ignored
      v0 = valid_cnt; e0 = err_cnt;
      i2c_start();
      i2c_byte(8'h35, a0);
      chk("t4_err_rw", 32'(err_cnt - e0), 32'd1);
      i2c_byte(8'h55, a1);
      i2c_stop();
      chk("t4_acks", 32'({a0, a1}), 32'h0);
      chk("t4_err_total", 32'(err_cnt - e0), 32'd1);
      chk("t4_valid", 32'(valid_cnt - v0), 32'd0);
      chk("t4_count", 32'(o_wr_count), 32'd3);

      // STOP before byte 2 aborts the write
      xfer3(8'h34, 8'h04, 8'h79, a0, a1, a2);
      v0 = valid_cnt; e0 = err_cnt;
      i2c_start();
      i2c_byte(8'h34, a0);
      i2c_byte(8'h12, a1);
      i2c_stop();
      chk("t5_acks", 32'({a0, a1}), 32'h3);
      rd_chk("t5_r2", 4'd2, 9'h079);
      rd_chk("t5_r9", 4'd9, 9'h000);
      chk("t5_err", 32'(err_cnt - e0), 32'd1);
      chk("t5_valid", 32'(valid_cnt - v0), 32'd0);
      chk("t5_busy", 32'(o_busy), 32'd0);
      chk("t5_count", 32'(o_wr_count), 32'd4);

      // Repeated START discards partial write; R6 rewritten to 0
      xfer3(8'h34, 8'h0D, 8'h55, a0, a1, a2);
      rd_chk("t6_r6_pre", 4'd6, 9'h155);
      v0 = valid_cnt; e0 = err_cnt;
      i2c_start();
      i2c_byte(8'h34, a0);
      i2c_byte(8'h16, a1);
      xfer3(8'h34, 8'h0C, 8'h00, a0, a1, a2);
      chk("t6_valid", 32'(valid_cnt - v0), 32'd1);
      chk("t6_err", 32'(err_cnt - e0), 32'd0);
      chk("t6_waddr", 32'(o_wr_addr), 32'h06);
      chk("t6_wdata", 32'(o_wr_data), 32'h000);
      chk("t6_count", 32'(o_wr_count), 32'd6);
      rd_chk("t6_r6", 4'd6, 9'h000);

      // Out-of-range register: committed, reported, file unchanged
      v0 = valid_cnt; e0 = err_cnt;
      xfer3(8'h34, 8'h14, 8'hAB, a0, a1, a2);
      chk("t7_acks", 32'({a0, a1, a2}), 32'h7);
      chk("t7_valid", 32'(valid_cnt - v0), 32'd1);
      chk("t7_err", 32'(err_cnt - e0), 32'd1);
      chk("t7_waddr", 32'(o_wr_addr), 32'h0A);
      chk("t7_wdata", 32'(o_wr_data), 32'h0AB);
      chk("t7_count", 32'(o_wr_count), 32'd7);
      rd_chk("t7_r10", 4'd10, 9'h000);
      rd_chk("t7_r15", 4'd15, 9'h000);
      rd_chk("t7_r2", 4'd2, 9'h079);

      // Reset while the address ACK is being driven
      i2c_start();
      send_bits(8'h34);
      chk("t8_oen_ack", 32'(bus.sda_oen), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t8_oen_rst", 32'(bus.sda_oen), 32'd0);
      chk("t8_busy_rst", 32'(o_busy), 32'd0);
      chk("t8_count_rst", 32'(o_wr_count), 32'd0);
      rd_chk("t8_r2_rst", 4'd2, 9'h000);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      scl_drv = 1'b1; wq();
      sda_drv = 1'b1; wq();
      xfer3(8'h34, 8'h12, 8'h01, a0, a1, a2);
      chk("t8_acks", 32'({a0, a1, a2}), 32'h7);
      chk("t8_count", 32'(o_wr_count), 32'd1);
      rd_chk("t8_r9", 4'd9, 9'h001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
